pc_fetch_unit: RTL and testbench
================================

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, giving the first fetch address after reset.
REQ-002 SHALL have parameter MEM_WORDS, default 64, giving instruction memory depth in 32-bit words.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port stall  input  1  freeze PC and fetch register this cycle.
REQ-006 SHALL have port halt  input  1  stop fetching permanently until reset.
REQ-007 SHALL have port branch  input  1  decoded instruction is a conditional branch.
REQ-008 SHALL have port zero  input  1  ALU zero flag qualifying branch.
REQ-009 SHALL have port branch_offset  input  32  sign-extended word offset.
REQ-010 SHALL have port jump  input  1  decoded instruction is j.
REQ-011 SHALL have port jump_index  input  26  j target field.
REQ-012 SHALL have port pc  output  32  byte read address to instruction memory.
REQ-013 SHALL have port instruction_in  input  32  combinational memory data for pc.
REQ-014 SHALL have port if_instruction  output  32  registered fetched instruction.
REQ-015 SHALL have port if_pc_plus4  output  32  registered address of fetched instruction plus 4.
REQ-016 SHALL have port if_valid  output  1  if_instruction is live and must execute.
REQ-017 SHALL have port fault  output  1  sticky out-of-range fetch indication.
REQ-018 SHALL have ports fetch_count and flush_count  output  32 each  performance counters.

Function
REQ-019 SHALL implement states IDLE, RUN, HALTED, FAULT; IDLE is entered on reset and moves to RUN unconditionally on the next edge.
REQ-020 In RUN without stall, SHALL capture instruction_in into if_instruction, pc+4 into if_pc_plus4, set if_valid=1, and advance pc each cycle.
REQ-021 Next pc SHALL be, in priority order: jump -> {if_pc_plus4[31:28], jump_index, 2'b00}; branch&&zero -> if_pc_plus4 + (branch_offset<<2), 32-bit wrap; else pc+4.
REQ-022 branch, zero and jump SHALL be honoured only when if_valid=1.
REQ-023 On redirect (jump or taken branch), the instruction fetched the same cycle SHALL be squashed: if_valid=0 on the next cycle; redirect latency is exactly one cycle.
REQ-024 stall=1 SHALL hold pc, if_instruction, if_pc_plus4, if_valid unchanged and ignore redirect inputs; stall dominates halt and redirect.
REQ-025 halt=1 in RUN without stall SHALL enter HALTED: pc frozen, if_valid=0 from the next cycle onward.
REQ-026 A computed next pc >= MEM_WORDS*4 SHALL enter FAULT instead of loading it: pc holds its last value, fault=1, if_valid=0; exit only by reset.
REQ-027 In IDLE, HALTED and FAULT, stall, branch and jump SHALL have no effect.

Reset
REQ-028 While reset=0, SHALL force pc=RESET_PC, if_instruction=0, if_pc_plus4=0, if_valid=0, fault=0, counters=0, state=IDLE, independent of clk.
REQ-029 Reset asserted mid-redirect or mid-stall SHALL discard the pending action; the first post-reset fetch is at RESET_PC.

Configuration
REQ-030 With FETCH_PERF_CNT_EN defined, fetch_count SHALL increment on each cycle that sets if_valid=1 and flush_count on each squash, both wrapping at 2^32.
REQ-031 Without FETCH_PERF_CNT_EN, fetch_count and flush_count SHALL be tied to 0 and no counter flops SHALL be built.

Verification
REQ-032 Release reset, no stimulus -> pc sequence 0,4,8,...; if_valid=0 on the first edge after reset, 1 thereafter; if_pc_plus4=4 when if_instruction=mem[0].
REQ-033 if_pc_plus4=0x28 with branch=1, zero=1, branch_offset=1 -> pc=0x2C next cycle, following if_valid=0, then instruction at 0x2C valid.
REQ-034 branch=1, zero=0 -> no redirect, pc continues +4, no squash, flush_count unchanged.
REQ-035 jump=1, jump_index=0x11, if_pc_plus4=0x3C -> pc=0x44; instructions at 0x3C and 0x40 never valid.
REQ-036 stall=1 for 3 cycles coincident with jump=1 -> pc, if_* constant for 3 cycles, jump ignored, sequential fetch resumes.
REQ-037 Branch target 0x100 with MEM_WORDS=64 -> fault=1, if_valid=0, pc frozen; reset=0 clears fault and restarts at RESET_PC.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Instruction fetch stage: PC sequencing, one-cycle-squash redirects, halt and out-of-range fault.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        halt,
    input  logic        branch,
    input  logic        zero,
    input  logic [31:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_index,
    output logic [31:0] pc,
    input  logic [31:0] instruction_in,
    output logic [31:0] if_instruction,
    output logic [31:0] if_pc_plus4,
    output logic        if_valid,
    output logic        fault,
    output logic [31:0] fetch_count,
    output logic [31:0] flush_count
);

    localparam logic [31:0] PC_LIMIT = 32'(MEM_WORDS * 4);

    typedef enum logic [1:0] {IDLE, RUN, HALTED, FAULT} state_t;

    state_t      state;
    logic [31:0] seq_pc;
    logic [31:0] next_pc;
    logic        take_jump;
    logic        take_branch;
    logic        redirect;
    logic        pc_oob;
    logic        fetch_fire;

    // Redirect qualifiers come from the instruction held in IF, so they only count when it is live.
    always_comb begin
        seq_pc      = pc + 32'd4;
        take_jump   = if_valid && jump;
        take_branch = if_valid && branch && zero;
        redirect    = take_jump || take_branch;
        if (take_jump)
            next_pc = {if_pc_plus4[31:28], jump_index, 2'b00};
        else if (take_branch)
            next_pc = if_pc_plus4 + (branch_offset << 2);
        else
            next_pc = seq_pc;
        pc_oob     = (next_pc >= PC_LIMIT);
        fetch_fire = (state == RUN) && !stall && !halt && !pc_oob;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            pc             <= RESET_PC;
            if_instruction <= '0;
            if_pc_plus4    <= '0;
            if_valid       <= 1'b0;
            fault          <= 1'b0;
        end else begin
            case (state)
                IDLE: state <= RUN;
                RUN: begin
                    if (!stall) begin
                        if (halt) begin
                            state    <= HALTED;
                            if_valid <= 1'b0;
                        end else if (pc_oob) begin
                            state    <= FAULT;
                            fault    <= 1'b1;
                            if_valid <= 1'b0;
                        end else begin
                            pc             <= next_pc;
                            if_instruction <= instruction_in;
                            if_pc_plus4    <= seq_pc;
                            if_valid       <= !redirect;
                        end
                    end
                end
                HALTED, FAULT: if_valid <= 1'b0;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_count <= '0;
            flush_count <= '0;
        end else if (fetch_fire) begin
            if (redirect)
                flush_count <= flush_count + 32'd1;
            else
                fetch_count <= fetch_count + 32'd1;
        end
    end
`else
    assign fetch_count = '0;
    assign flush_count = '0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: stimulus queues expected fetches, a monitor checks live IF outputs.
module tb_pc_fetch_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        halt;
    logic        branch;
    logic        zero;
    logic [31:0] branch_offset;
    logic        jump;
    logic [25:0] jump_index;
    logic [31:0] pc;
    logic [31:0] instruction_in;
    logic [31:0] if_instruction;
    logic [31:0] if_pc_plus4;
    logic        if_valid;
    logic        fault;
    logic [31:0] fetch_count;
    logic [31:0] flush_count;

`ifdef FETCH_PERF_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } fetch_t;

    fetch_t queue_exp[$];
    int     checks = 0;
    int     errors = 0;
    logic   edge_stalled = 1'b0;

    pc_fetch_unit #(.RESET_PC(32'h0000_0000), .MEM_WORDS(64)) dut (
        .clk(clk), .reset(reset), .stall(stall), .halt(halt),
        .branch(branch), .zero(zero), .branch_offset(branch_offset),
        .jump(jump), .jump_index(jump_index), .pc(pc),
        .instruction_in(instruction_in), .if_instruction(if_instruction),
        .if_pc_plus4(if_pc_plus4), .if_valid(if_valid), .fault(fault),
        .fetch_count(fetch_count), .flush_count(flush_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction memory model: each word encodes its own byte address.
    always_comb instruction_in = (pc < 32'd256) ? (32'hC0DE_0000 | pc) : 32'hBAD0_BAD0;

    always @(posedge clk) edge_stalled = stall;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_fetch(input logic [31:0] addr);
        fetch_t e;
        e.instr = 32'hC0DE_0000 | addr;
        e.pc4   = addr + 32'd4;
        queue_exp.push_back(e);
    endtask

    task automatic wait_fetch(input logic [31:0] p4);
        bit seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (if_valid && if_pc_plus4 == p4) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL wait_fetch: if_pc_plus4 %h never live, expected %h", if_pc_plus4, p4);
        end
    endtask

    // Monitor: every newly captured live instruction must match the head of the queue.
    initial begin
        fetch_t e;
        forever begin
            @(negedge clk);
            if (reset && if_valid && !edge_stalled) begin
                checks++;
                if (queue_exp.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_fetch: got pc4 %h expected none", if_pc_plus4);
                end else begin
                    e = queue_exp.pop_front();
                    if (if_instruction !== e.instr || if_pc_plus4 !== e.pc4) begin
                        errors++;
                        $display("FAIL fetch: got %h/%h expected %h/%h",
                                 if_instruction, if_pc_plus4, e.instr, e.pc4);
                    end
                end
            end
        end
    end

    initial begin
        reset = 1'b1; stall = 1'b0; halt = 1'b0; branch = 1'b0; zero = 1'b0;
        branch_offset = '0; jump = 1'b0; jump_index = '0;
        #1 reset = 1'b0;
        #1;
        check32("rst_pc", pc, 32'h0);
        check32("rst_valid", {31'b0, if_valid}, 32'h0);
        check32("rst_pc4", if_pc_plus4, 32'h0);
        check32("rst_fault", {31'b0, fault}, 32'h0);

        for (int a = 0; a <= 32'h24; a += 4) push_fetch(32'(a));
        push_fetch(32'h2C); push_fetch(32'h30); push_fetch(32'h34); push_fetch(32'h38);
        push_fetch(32'h44); push_fetch(32'h48); push_fetch(32'h4C);

        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check32("idle_valid", {31'b0, if_valid}, 32'h0);
        check32("idle_pc", pc, 32'h0);
        @(negedge clk);
        check32("first_valid", {31'b0, if_valid}, 32'h1);
        check32("first_pc", pc, 32'h4);
        check32("first_pc4", if_pc_plus4, 32'h4);

        // Taken branch from 0x24: target 0x28 + 4.
        wait_fetch(32'h28);
        branch = 1'b1; zero = 1'b1; branch_offset = 32'd1;
        @(negedge clk);
        branch = 1'b0; zero = 1'b0; branch_offset = '0;
        check32("br_pc", pc, 32'h2C);
        check32("br_squash", {31'b0, if_valid}, 32'h0);

        // Not-taken branch.
        wait_fetch(32'h30);
        branch = 1'b1; zero = 1'b0;
        @(negedge clk);
        branch = 1'b0;
        check32("nt_pc", pc, 32'h34);
        check32("nt_valid", {31'b0, if_valid}, 32'h1);
        check32("nt_flush", flush_count, CNT_ON ? 32'd1 : 32'd0);

        // Jump to 0x44.
        wait_fetch(32'h3C);
        jump = 1'b1; jump_index = 26'h11;
        @(negedge clk);
        jump = 1'b0; jump_index = '0;
        check32("j_pc", pc, 32'h44);
        check32("j_squash", {31'b0, if_valid}, 32'h0);

        // Stall with a coincident jump is ignored for three cycles.
        wait_fetch(32'h48);
        stall = 1'b1; jump = 1'b1; jump_index = 26'h3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check32("st_pc", pc, 32'h48);
            check32("st_pc4", if_pc_plus4, 32'h48);
            check32("st_instr", if_instruction, 32'hC0DE_0044);
            check32("st_valid", {31'b0, if_valid}, 32'h1);
        end
        stall = 1'b0; jump = 1'b0; jump_index = '0;
        @(negedge clk);
        check32("st_resume", pc, 32'h4C);

        // Branch target 0x50 + 0x2C*4 = 0x100 is out of range.
        wait_fetch(32'h50);
        branch = 1'b1; zero = 1'b1; branch_offset = 32'h2C;
        @(negedge clk);
        check32("flt_fault", {31'b0, fault}, 32'h1);
        check32("flt_pc", pc, 32'h50);
        check32("flt_valid", {31'b0, if_valid}, 32'h0);
        branch = 1'b0; zero = 1'b0; stall = 1'b1; jump = 1'b1;
        repeat (2) @(negedge clk);
        check32("flt_hold", pc, 32'h50);
        check32("flt_fetches", fetch_count, CNT_ON ? 32'd17 : 32'd0);
        check32("flt_flushes", flush_count, CNT_ON ? 32'd2 : 32'd0);

        // Asynchronous reset mid-stall / mid-jump.
        #3 reset = 1'b0;
        #1;
        check32("ar_pc", pc, 32'h0);
        check32("ar_fault", {31'b0, fault}, 32'h0);
        check32("ar_valid", {31'b0, if_valid}, 32'h0);
        check32("ar_fetches", fetch_count, 32'h0);
        stall = 1'b0; jump = 1'b0; branch_offset = '0;
        push_fetch(32'h0); push_fetch(32'h4); push_fetch(32'h8);
        @(negedge clk);
        reset = 1'b1;

        // Halt once the instruction at 0x08 is live.
        wait_fetch(32'h0C);
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        check32("h_pc", pc, 32'h0C);
        check32("h_valid", {31'b0, if_valid}, 32'h0);
        jump = 1'b1; jump_index = 26'h5;
        repeat (2) @(negedge clk);
        jump = 1'b0;
        check32("h_hold", pc, 32'h0C);
        check32("h_valid2", {31'b0, if_valid}, 32'h0);
        check32("h_fetches", fetch_count, CNT_ON ? 32'd3 : 32'd0);
        check32("sb_empty", 32'(queue_exp.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
